// File: rtl/avmm_reg_master_pkg.sv
// Shared types and constants for the Avalon-MM register master: FSM encoding,
// counter widths and the register map of the default RearLights slave.
package avmm_reg_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_RDWAIT = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    localparam int LAT_W = 3;
    localparam int TMO_W = 8;

    // Word addresses on the s0 port, so sequencers can use symbolic names
    localparam logic [3:0] RL_REG_CTRL   = 4'h0;
    localparam logic [3:0] RL_REG_STATUS = 4'h1;
    localparam logic [3:0] RL_REG_BRAKE  = 4'h2;
    localparam logic [3:0] RL_REG_TURN   = 4'h3;
    localparam logic [3:0] RL_REG_PWM    = 4'h4;

endpackage

// File: rtl/avmm_reg_master.sv
// Single-beat Avalon-MM master: one command in, one response out, with
// fixed read latency, waitrequest support and a stall timeout.
module avmm_reg_master
    import avmm_reg_master_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic              clock200_clk,
    input  logic              reset_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic              rsp_error,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic [ADDR_W-1:0] m0_address,
    output logic              m0_read,
    output logic              m0_write,
    output logic [DATA_W-1:0] m0_writedata,
    input  logic [DATA_W-1:0] m0_readdata,
    input  logic              m0_waitrequest
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] m0_address_q, m0_address_d;
    logic              m0_read_q, m0_read_d;
    logic              m0_write_q, m0_write_d;
    logic [DATA_W-1:0] m0_writedata_q, m0_writedata_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic              rsp_error_q, rsp_error_d;
    logic [DATA_W-1:0] rsp_readdata_q, rsp_readdata_d;
    logic              stall_abort;

    // The count only reaches TIMEOUT-1 in stalled cycles, so one more stall aborts
    assign stall_abort = (TIMEOUT != 0) && m0_waitrequest && (tmo_q == TMO_LAST);

    always_comb begin
        state_d        = state_q;
        m0_address_d   = m0_address_q;
        m0_read_d      = m0_read_q;
        m0_write_d     = m0_write_q;
        m0_writedata_d = m0_writedata_q;
        lat_d          = lat_q;
        tmo_d          = tmo_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_write_d    = rsp_write_q;
        rsp_error_d    = rsp_error_q;
        rsp_readdata_d = rsp_readdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    m0_address_d   = cmd_address;
                    m0_write_d     = cmd_write;
                    m0_read_d      = !cmd_write;
                    m0_writedata_d = cmd_write ? cmd_writedata : '0;
                    tmo_d          = '0;
                    state_d        = cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE, ST_READ: begin
                if (!m0_waitrequest || stall_abort) begin
                    m0_read_d      = 1'b0;
                    m0_write_d     = 1'b0;
                    m0_writedata_d = '0;
                    if (!m0_waitrequest && state_q == ST_READ) begin
                        lat_d   = LAT_LOAD;
                        state_d = ST_RDWAIT;
                    end else begin
                        rsp_valid_d    = 1'b1;
                        rsp_write_d    = (state_q == ST_WRITE);
                        rsp_error_d    = stall_abort;
                        rsp_readdata_d = '0;
                        state_d        = ST_RESP;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RDWAIT: begin
                if (lat_q == '0) begin
                    rsp_valid_d    = 1'b1;
                    rsp_write_d    = 1'b0;
                    rsp_error_d    = 1'b0;
                    rsp_readdata_d = m0_readdata;
                    state_d        = ST_RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock200_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q        <= ST_IDLE;
            m0_address_q   <= '0;
            m0_read_q      <= 1'b0;
            m0_write_q     <= 1'b0;
            m0_writedata_q <= '0;
            lat_q          <= '0;
            tmo_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_write_q    <= 1'b0;
            rsp_error_q    <= 1'b0;
            rsp_readdata_q <= '0;
        end else begin
            state_q        <= state_d;
            m0_address_q   <= m0_address_d;
            m0_read_q      <= m0_read_d;
            m0_write_q     <= m0_write_d;
            m0_writedata_q <= m0_writedata_d;
            lat_q          <= lat_d;
            tmo_q          <= tmo_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_write_q    <= rsp_write_d;
            rsp_error_q    <= rsp_error_d;
            rsp_readdata_q <= rsp_readdata_d;
        end
    end

    // Held low while reset is applied even though the state reads IDLE
    assign cmd_ready    = (state_q == ST_IDLE) && !reset_reset;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_write    = rsp_write_q;
    assign rsp_error    = rsp_error_q;
    assign rsp_readdata = rsp_readdata_q;
    assign m0_address   = m0_address_q;
    assign m0_read      = m0_read_q;
    assign m0_write     = m0_write_q;
    assign m0_writedata = m0_writedata_q;

endmodule
